// File: rtl/product_bcd_display.sv
// Converts an 8-bit product to three BCD digits (sequential double-dabble) and scans them onto one 7-segment driver.
// Latency: 8 cycles from capture to bcd_out; the segment scan runs freely with SCAN_DIV cycles per digit.
// Backpressure: none; strobes that arrive while busy is high are dropped, and there is no queue.
module product_bcd_display #(
    parameter int SCAN_DIV   = 16,
    parameter int BLANK_LEAD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  prod_in,
    input  logic        prod_valid,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          bcd_vld_q, bcd_vld_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    dig_q, dig_d;

    logic [11:0]   adj;
    logic [11:0]   shifted;
    // The hundreds nibble never exceeds 2, so the bit shifted out of it is always zero.
    logic          shift_out_unused;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture in IDLE, leave CONV after the 8th shift
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (prod_valid)      state_d = CONV;
            CONV:    if (cnt_q == 3'd7)   state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == CONV);
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift {scratch, binary} left by one
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted          = {adj[10:0], bin_q[7]};
        shift_out_unused = adj[11];
    end

    // Conversion datapath next-state; bcd_out only moves when a conversion completes
    always_comb begin
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        bcd_vld_d = bcd_vld_q;
        if (state_q == IDLE) begin
            if (prod_valid) begin
                bin_d     = prod_in;
                scratch_d = 12'h000;
                cnt_d     = 3'd0;
            end
        end else begin
            bin_d     = {bin_q[6:0], 1'b0};
            scratch_d = shifted;
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                bcd_d     = shifted;
                bcd_vld_d = 1'b1;
            end
        end
    end

    // Conversion datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= 8'h00;
            scratch_q <= 12'h000;
            cnt_q     <= 3'd0;
            bcd_q     <= 12'h000;
            bcd_vld_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            bcd_vld_q <= bcd_vld_d;
        end
    end

    // Free-running scan divider; rotate the digit enable on each wrap
    always_comb begin
        div_d = div_q + DW'(1);
        dig_d = dig_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            dig_d = {dig_q[1:0], dig_q[2]};
        end
    end

    // Scan registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            dig_q <= 3'b001;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
        end
    end

    // Segment decode with leading-zero blanking; dash until the first result exists
    always_comb begin
        logic [3:0] nib;
        logic       blank;
        nib   = bcd_q[3:0];
        blank = 1'b0;
        case (dig_q)
            3'b100: begin
                nib   = bcd_q[11:8];
                blank = (BLANK_LEAD != 0) && (bcd_q[11:8] == 4'd0);
            end
            3'b010: begin
                nib   = bcd_q[7:4];
                blank = (BLANK_LEAD != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            default: begin
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
        endcase
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank) begin
            seg = 7'h00;
        end
        if (!bcd_vld_q) begin
            seg = 7'h40;
        end
    end

    assign bcd_out   = bcd_q;
    assign bcd_valid = bcd_vld_q;
    assign dig_sel   = dig_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display: reset, conversion latency and values, blanking, dropped strobes, reset mid-conversion, full sweep.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
// No backpressure exists; strobes are timed relative to busy.
module tb_product_bcd_display;

    localparam int SD = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        busy;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;

    int checks;
    int errors;
    int cyc;

    product_bcd_display #(
        .SCAN_DIV   (SD),
        .BLANK_LEAD (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .seg        (seg),
        .dig_sel    (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Strobe one product, then count cycles until busy falls; checks latency and that bcd_out holds meanwhile.
    task automatic do_conv(input logic [7:0] p, input logic [11:0] exp_bcd, input string tag);
        int n;
        logic [11:0] prev;
        logic moved;
        prev       = bcd_out;
        moved      = 1'b0;
        prod_in    = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        prod_in    = 8'($urandom);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (bcd_out !== prev) moved = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_hold"}, moved, 0);
        chk({tag, "_bcd"}, bcd_out, exp_bcd);
        chk({tag, "_valid"}, bcd_valid, 1);
    endtask

    task automatic wait_dig(input logic [2:0] tgt);
        int n;
        n = 0;
        while (dig_sel !== tgt && n < 4 * SD) begin
            tick();
            n++;
        end
        chk("dig_wait", dig_sel, tgt);
    endtask

    task automatic check_scan(input string tag, input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so);
        wait_dig(3'b100);
        chk({tag, "_seg_h"}, seg, sh);
        wait_dig(3'b010);
        chk({tag, "_seg_t"}, seg, st);
        wait_dig(3'b001);
        chk({tag, "_seg_o"}, seg, so);
    endtask

    initial begin
        int cap;
        int prev_cap;
        logic [11:0] exp_bcd;
        int n;

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        prod_in    = 8'h00;
        prod_valid = 1'b0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_bcd", bcd_out, 12'h000);
        chk("rst_valid", bcd_valid, 0);
        chk("rst_dig", dig_sel, 3'b001);
        chk("rst_seg", seg, 7'h40);
        for (int i = 0; i < SD - 1; i++) tick();
        chk("scan_before_wrap", dig_sel, 3'b001);
        tick();
        chk("scan_first_wrap", dig_sel, 3'b010);
        chk("dash_tens", seg, 7'h40);

        // Max product 15x15 = 225
        do_conv(8'hE1, 12'h225, "max");
        check_scan("max", 7'h5B, 7'h5B, 7'h6D);

        // Strobes during busy (3 cycles in, and on the completing edge) are dropped
        prod_in    = 8'h64;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("sb_busy_start", busy, 1);
        tick();
        tick();
        prod_in    = 8'h0A;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("sb_busy_mid", busy, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("sb_busy_n7", busy, 1);
        chk("sb_bcd_n7", bcd_out, 12'h225);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        chk("sb_busy_n8", busy, 0);
        chk("sb_bcd", bcd_out, 12'h100);
        tick();
        chk("sb_dropped_last", busy, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("sb_bcd_after", bcd_out, 12'h100);

        // Leading-zero blanking
        do_conv(8'h07, 12'h007, "blank7");
        check_scan("blank7", 7'h00, 7'h00, 7'h07);
        do_conv(8'h64, 12'h100, "blank100");
        check_scan("blank100", 7'h06, 7'h3F, 7'h3F);

        // Reset during the 4th cycle of conversion
        prod_in    = 8'hC8;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bcd", bcd_out, 12'h000);
        chk("mid_rst_valid", bcd_valid, 0);
        chk("mid_rst_dig", dig_sel, 3'b001);
        chk("mid_rst_seg", seg, 7'h40);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        do_conv(8'h2A, 12'h042, "after_rst");
        check_scan("after_rst", 7'h00, 7'h66, 7'h5B);

        // Full sweep, back-to-back strobes
        prev_cap = 0;
        for (int v = 0; v < 256; v++) begin
            exp_bcd    = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            prod_in    = 8'(v);
            prod_valid = 1'b1;
            tick();
            cap        = cyc;
            prod_valid = 1'b0;
            chk("sweep_capture", busy, 1);
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("sweep_latency", n, 8);
            chk("sweep_bcd", bcd_out, exp_bcd);
            if (v > 0) chk("sweep_spacing", cap - prev_cap, 9);
            prev_cap = cap;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
